// File: rtl/vshift_lane_seq.sv
// Element-wise vector shift sequencer feeding a 64-bit doubleword shifter one lane at a time.
// Optional build macro VSHIFT_SEQ_FLUSH_EN adds a flush input that aborts RUN/DONE back to IDLE.
//
// state   | meaning
// S_IDLE  | ready for a request, shifter inputs held at zero
// S_DRIVE | current lane driven onto the shifter
// S_CAPTURE | registered shifter output written into the result lane (REG_SH_OUT=1 only)
// S_DONE  | result presented, waiting for out_ready
module vshift_lane_seq #(
    parameter int REG_SH_OUT = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  op,
    input  logic [1:0]  ww,
    input  logic [63:0] ra_data,
    input  logic [63:0] rb_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] result,
    output logic [63:0] sh_data_in,
    output logic [6:0]  sh_amt,
    output logic        sh_data_tc,
    output logic        sh_sh_tc,
    output logic        sh_mode,
    input  logic [63:0] sh_data_out
`ifdef VSHIFT_SEQ_FLUSH_EN
    ,
    input  logic        flush
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_ROTL = 2'b11;

    state_t      state;
    logic [2:0]  lane;
    logic [1:0]  op_q;
    logic [1:0]  ww_q;
    logic [63:0] ra_q;
    logic [63:0] rb_q;
    logic [63:0] sh_q;

    logic [5:0]  lane_off;
    logic [63:0] e_raw;
    logic [5:0]  a_raw;
    logic [63:0] elem_zx;
    logic [63:0] elem_sx;
    logic [63:0] elem_rep;
    logic [6:0]  amt;
    logic [6:0]  amt_neg;
    logic [63:0] lane_mask;
    logic [2:0]  last_lane;
    logic        running;
    logic [63:0] cap_src;
    logic [63:0] merged;

    // Lane k starts at bit k*W, i.e. lane*8 scaled by the width code.
    assign lane_off  = {lane, 3'b000} << ww_q;
    assign e_raw     = ra_q >> lane_off;
    assign a_raw     = 6'(rb_q >> lane_off);
    assign last_lane = 3'((4'd8 >> ww_q) - 4'd1);
    assign running   = (state == S_DRIVE) || (state == S_CAPTURE);
    assign in_ready  = (state == S_IDLE);

    always_comb begin
        elem_zx   = 64'd0;
        elem_sx   = 64'd0;
        elem_rep  = 64'd0;
        amt       = 7'd0;
        lane_mask = 64'd0;
        case (ww_q)
            2'b00: begin
                elem_zx   = {56'd0, e_raw[7:0]};
                elem_sx   = {{56{e_raw[7]}}, e_raw[7:0]};
                elem_rep  = {8{e_raw[7:0]}};
                amt       = {4'd0, a_raw[2:0]};
                lane_mask = 64'h0000_0000_0000_00FF;
            end
            2'b01: begin
                elem_zx   = {48'd0, e_raw[15:0]};
                elem_sx   = {{48{e_raw[15]}}, e_raw[15:0]};
                elem_rep  = {4{e_raw[15:0]}};
                amt       = {3'd0, a_raw[3:0]};
                lane_mask = 64'h0000_0000_0000_FFFF;
            end
            2'b10: begin
                elem_zx   = {32'd0, e_raw[31:0]};
                elem_sx   = {{32{e_raw[31]}}, e_raw[31:0]};
                elem_rep  = {2{e_raw[31:0]}};
                amt       = {2'd0, a_raw[4:0]};
                lane_mask = 64'h0000_0000_FFFF_FFFF;
            end
            default: begin
                elem_zx   = e_raw;
                elem_sx   = e_raw;
                elem_rep  = e_raw;
                amt       = {1'b0, a_raw};
                lane_mask = 64'hFFFF_FFFF_FFFF_FFFF;
            end
        endcase
    end

    // Right shifts are requested as a negative two's-complement distance.
    assign amt_neg = 7'd0 - amt;

    always_comb begin
        sh_data_in = 64'd0;
        sh_amt     = 7'd0;
        sh_data_tc = 1'b0;
        sh_sh_tc   = 1'b0;
        sh_mode    = 1'b0;
        if (running) begin
            case (op_q)
                OP_SLL: begin
                    sh_data_in = elem_zx;
                    sh_amt     = amt;
                    sh_mode    = 1'b1;
                end
                OP_SRL: begin
                    sh_data_in = elem_zx;
                    sh_amt     = amt_neg;
                    sh_sh_tc   = 1'b1;
                    sh_mode    = 1'b1;
                end
                OP_SRA: begin
                    sh_data_in = elem_sx;
                    sh_amt     = amt_neg;
                    sh_sh_tc   = 1'b1;
                    sh_data_tc = 1'b1;
                    sh_mode    = 1'b1;
                end
                default: begin
                    sh_data_in = elem_rep;
                    sh_amt     = amt;
                end
            endcase
        end
    end

    assign cap_src = (REG_SH_OUT != 0) ? sh_q : sh_data_out;
    assign merged  = result | ((cap_src & lane_mask) << lane_off);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            lane      <= 3'd0;
            op_q      <= 2'd0;
            ww_q      <= 2'd0;
            ra_q      <= 64'd0;
            rb_q      <= 64'd0;
            sh_q      <= 64'd0;
            result    <= 64'd0;
            out_valid <= 1'b0;
        end else
`ifdef VSHIFT_SEQ_FLUSH_EN
        if (flush && (state != S_IDLE)) begin
            state     <= S_IDLE;
            lane      <= 3'd0;
            out_valid <= 1'b0;
        end else
`endif
        begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        op_q   <= op;
                        ww_q   <= ww;
                        ra_q   <= ra_data;
                        rb_q   <= rb_data;
                        lane   <= 3'd0;
                        result <= 64'd0;
                        state  <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    if (REG_SH_OUT != 0) begin
                        sh_q  <= sh_data_out;
                        state <= S_CAPTURE;
                    end else begin
                        result <= merged;
                        if (lane == last_lane) begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                        end else begin
                            lane <= lane + 3'd1;
                        end
                    end
                end
                S_CAPTURE: begin
                    result <= merged;
                    if (lane == last_lane) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                    end else begin
                        lane  <= lane + 3'd1;
                        state <= S_DRIVE;
                    end
                end
                default: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
            endcase
        end
    end

endmodule
